mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: N, 16, address/data width.
REQ-002 Parameter: TIMEOUT, 15, max cycles in BUSY before abort.
REQ-003 clk  input  1  clock; sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  fetch read request; held until i_done.
REQ-006 i_addr  input  N  fetch address.
REQ-007 i_rdata  output  N  fetch read data; valid while i_done.
REQ-008 i_done  output  1  one-cycle fetch completion pulse.
REQ-009 i_stall  output  1  fetch must hold.
REQ-010 d_rd, d_wr  input  1 each  data read/write request; held until d_done.
REQ-011 d_addr, d_wdata  input  N each  data address, write data.
REQ-012 d_rdata  output  N  data read result; valid while d_done.
REQ-013 d_done  output  1  one-cycle data completion pulse.
REQ-014 d_stall  output  1  data port must hold.
REQ-015 mem_rd, mem_wr  output  1 each  command to shared memory system.
REQ-016 mem_addr, mem_wdata  output  N each  registered address/write data to memory.
REQ-017 mem_rdata  input  N  memory read data.
REQ-018 mem_done  input  1  memory access complete.
REQ-019 mem_err  input  1  memory error, sampled with mem_done.
REQ-020 err  output  1  sticky error flag.

Function
REQ-021 FSM SHALL have states IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I.
REQ-022 IDLE, only D pending (d_rd|d_wr): latch addr/wdata/op, go BUSY_D; only i_req: latch i_addr, go BUSY_I.
REQ-023 IDLE, both pending: grant port not last served; last_served resets to I so D wins first tie.
REQ-024 mem_rd/mem_wr SHALL be asserted only in BUSY_x, from latched op, cycle after grant, held until mem_done or timeout.
REQ-025 mem_addr/mem_wdata SHALL stay constant for whole BUSY interval regardless of requester input changes.
REQ-026 BUSY_x with mem_done: capture mem_rdata, go RESP_x, update last_served.
REQ-027 RESP_x: assert x_done and x_rdata for exactly one cycle; no grant taken; next state IDLE.
REQ-028 Min latency request->done: 3 cycles (grant, memory cycle with mem_done, RESP).
REQ-029 x_stall = x request active & ~x_done, combinational.
REQ-030 Cycle counter SHALL clear on grant, increment each BUSY cycle; at TIMEOUT without mem_done: set err, drop command, go RESP_x with rdata 0.
REQ-031 mem_err high with mem_done SHALL set err; response still delivered.
REQ-032 d_rd & d_wr both high at grant: set err, no memory command, go RESP_D directly.
REQ-033 err SHALL remain set until reset.
REQ-034 Request withdrawn mid-BUSY SHALL NOT abort the access; RESP still issued.

Reset
REQ-035 On rst at clock edge: state IDLE, counter 0, last_served=I, err 0, mem_rd/mem_wr 0, all done 0, rdata registers 0.
REQ-036 rst during BUSY SHALL abandon access with no RESP pulse; no command asserted cycle after reset.

Verification
REQ-037 d_rd, d_addr=0x0040, mem_done 2nd BUSY cycle with mem_rdata=0xBEEF -> mem_rd 2 cycles, d_done one cycle, d_rdata=0xBEEF.
REQ-038 i_req and d_wr asserted same cycle after reset -> D served first, then I; each done pulses once, mem_wr precedes mem_rd.
REQ-039 Both ports continuously requesting -> grants alternate D,I,D,I; no port waits two grants.
REQ-040 mem_done never asserted -> after 15 BUSY cycles err=1, mem_rd drops, done pulses with rdata 0x0000.
REQ-041 d_rd=d_wr=1 -> no mem command, err=1, d_done next cycle.
REQ-042 rst asserted during BUSY_I -> next cycle IDLE, mem_rd=0, i_done never pulses, err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single shared memory channel.
// Fair tie-break, registered memory command, per-access timeout and sticky error.
module mem_arbiter #(
    parameter int N       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [N-1:0] i_addr,
    output logic [N-1:0] i_rdata,
    output logic         i_done,
    output logic         i_stall,
    input  logic         d_rd,
    input  logic         d_wr,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic [N-1:0] d_rdata,
    output logic         d_done,
    output logic         d_stall,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_done,
    input  logic         mem_err,
    output logic         err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_D,
        BUSY_I,
        RESP_D,
        RESP_I
    } state_t;

    state_t         state, state_nxt;
    logic           op_rd, op_wr;
    logic [N-1:0]   addr_q, wdata_q, rdata_q;
    logic [CW-1:0]  cnt;
    logic           last_d;
    logic           err_q;

    logic d_pend, d_both, grant_d, grant_i, busy, timeout;

    assign d_pend  = d_rd | d_wr;
    assign d_both  = d_rd & d_wr;
    // On a tie the port that was not served last wins.
    assign grant_d = d_pend & (~i_req | ~last_d);
    assign grant_i = i_req & ~grant_d;
    assign busy    = (state == BUSY_D) || (state == BUSY_I);
    assign timeout = (cnt == CW'(TIMEOUT - 1)) & ~mem_done;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = d_both ? RESP_D : BUSY_D;
                else if (grant_i) state_nxt = BUSY_I;
            end
            BUSY_D:  if (mem_done || timeout) state_nxt = RESP_D;
            BUSY_I:  if (mem_done || timeout) state_nxt = RESP_I;
            RESP_D:  state_nxt = IDLE;
            RESP_I:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
            last_d  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        op_rd   <= d_rd & ~d_wr;
                        op_wr   <= d_wr & ~d_rd;
                        if (d_both) begin
                            // Conflicting op: answer at once without touching memory.
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            last_d  <= 1'b1;
                        end
                    end else if (grant_i) begin
                        addr_q <= i_addr;
                        op_rd  <= 1'b1;
                        op_wr  <= 1'b0;
                    end
                end
                BUSY_D, BUSY_I: begin
                    cnt <= cnt + 1'b1;
                    if (mem_done) begin
                        rdata_q <= mem_rdata;
                        last_d  <= (state == BUSY_D);
                        if (mem_err) err_q <= 1'b1;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        last_d  <= (state == BUSY_D);
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd    = busy & op_rd;
    assign mem_wr    = busy & op_wr;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign i_done  = (state == RESP_I);
    assign d_done  = (state == RESP_D);
    assign i_rdata = i_done ? rdata_q : '0;
    assign d_rdata = d_done ? rdata_q : '0;
    assign i_stall = i_req & ~i_done;
    assign d_stall = d_pend & ~d_done;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus sequences for
// alternation, timeout, reset mid-access and withdrawn requests.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_done, i_stall;
    logic        d_rd, d_wr;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        d_done, d_stall;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_done, mem_err;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.N(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err), .err(err)
    );

    typedef struct {
        logic        rst, ireq, drd, dwr, mdone, merr;
        logic [15:0] mrdata;
        logic [6:0]  ctl;    // {mem_rd, mem_wr, i_done, d_done, err, i_stall, d_stall}
        logic [15:0] rdata;
        logic [15:0] maddr;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic r, logic ir, logic dr, logic dw, logic md, logic me,
                                logic [15:0] mrd, logic [6:0] c, logic [15:0] rd, logic [15:0] ma);
        vec_t v;
        v.rst = r; v.ireq = ir; v.drd = dr; v.dwr = dw; v.mdone = md; v.merr = me;
        v.mrdata = mrd; v.ctl = c; v.rdata = rd; v.maddr = ma;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 0; d_rd = 0; d_wr = 0; mem_done = 0; mem_err = 0; mem_rdata = '0;
        i_addr = 16'h0100; d_addr = 16'h0040; d_wdata = 16'h1234;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    initial begin
        logic [6:0]  ctl;
        logic [31:0] exp_rd;
        int          order[$];
        int          busy_cycles;
        int          addr_bad;
        bit          seen;

        tbl[0]  = mk(1,0,0,0,0,0,16'h0000, 7'b0000000, 16'h0000, 16'h0000);
        tbl[1]  = mk(0,0,1,0,0,0,16'h0000, 7'b0000001, 16'h0000, 16'h0000);
        tbl[2]  = mk(0,0,1,0,0,0,16'h0000, 7'b1000001, 16'h0000, 16'h0040);
        tbl[3]  = mk(0,0,1,0,1,0,16'hBEEF, 7'b1000001, 16'h0000, 16'h0040);
        tbl[4]  = mk(0,0,1,0,0,0,16'h0000, 7'b0001000, 16'hBEEF, 16'h0000);
        tbl[5]  = mk(1,0,0,0,0,0,16'h0000, 7'b0000000, 16'h0000, 16'h0000);
        tbl[6]  = mk(0,1,0,1,0,0,16'h0000, 7'b0000011, 16'h0000, 16'h0000);
        tbl[7]  = mk(0,1,0,1,1,0,16'h5555, 7'b0100011, 16'h0000, 16'h0040);
        tbl[8]  = mk(0,1,0,1,0,0,16'h0000, 7'b0001010, 16'h5555, 16'h0000);
        tbl[9]  = mk(0,1,0,0,0,0,16'h0000, 7'b0000010, 16'h0000, 16'h0000);
        tbl[10] = mk(0,1,0,0,1,0,16'hA5A5, 7'b1000010, 16'h0000, 16'h0100);
        tbl[11] = mk(0,1,0,0,0,0,16'h0000, 7'b0010000, 16'hA5A5, 16'h0000);
        tbl[12] = mk(0,0,0,0,0,0,16'h0000, 7'b0000000, 16'h0000, 16'h0000);
        tbl[13] = mk(0,0,1,1,0,0,16'h0000, 7'b0000001, 16'h0000, 16'h0000);
        tbl[14] = mk(0,0,1,1,0,0,16'h0000, 7'b0001100, 16'h0000, 16'h0000);
        tbl[15] = mk(0,0,0,0,0,0,16'h0000, 7'b0000100, 16'h0000, 16'h0000);
        tbl[16] = mk(1,0,0,0,0,0,16'h0000, 7'b0000100, 16'h0000, 16'h0000);
        tbl[17] = mk(0,1,0,0,0,0,16'h0000, 7'b0000010, 16'h0000, 16'h0000);
        tbl[18] = mk(0,1,0,0,1,1,16'h0F0F, 7'b1000010, 16'h0000, 16'h0100);
        tbl[19] = mk(0,1,0,0,0,0,16'h0000, 7'b0010100, 16'h0F0F, 16'h0000);
        tbl[20] = mk(0,0,0,0,0,0,16'h0000, 7'b0000100, 16'h0000, 16'h0000);
        tbl[21] = mk(1,0,0,0,0,0,16'h0000, 7'b0000100, 16'h0000, 16'h0000);
        tbl[22] = mk(0,0,0,0,0,0,16'h0000, 7'b0000000, 16'h0000, 16'h0000);

        do_reset();
        rst = 1;

        for (int k = 0; k < 23; k++) begin
            rst = tbl[k].rst; i_req = tbl[k].ireq; d_rd = tbl[k].drd; d_wr = tbl[k].dwr;
            mem_done = tbl[k].mdone; mem_err = tbl[k].merr; mem_rdata = tbl[k].mrdata;
            @(negedge clk);
            ctl = tbl[k].ctl;
            check($sformatf("vec%0d ctl", k),
                  {25'd0, mem_rd, mem_wr, i_done, d_done, err, i_stall, d_stall}, {25'd0, ctl});
            exp_rd = {ctl[4] ? tbl[k].rdata : 16'h0000, ctl[3] ? tbl[k].rdata : 16'h0000};
            check($sformatf("vec%0d rdata", k), {i_rdata, d_rdata}, exp_rd);
            if (ctl[6] || ctl[5])
                check($sformatf("vec%0d mem_addr", k), {16'd0, mem_addr}, {16'd0, tbl[k].maddr});
            next_cycle();
        end

        // Both ports requesting continuously: grants alternate D, I, D, I.
        do_reset();
        i_req = 1; d_rd = 1; mem_done = 1; mem_rdata = 16'h1111;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (d_done) order.push_back(1);
            if (i_done) order.push_back(0);
            next_cycle();
        end
        check("alt count", order.size(), 4);
        for (int j = 0; j < 4; j++)
            check($sformatf("alt grant%0d", j), (j < order.size()) ? order[j] : 9, (j % 2 == 0) ? 1 : 0);

        // Memory never answers: abort after TIMEOUT busy cycles; address held stable.
        do_reset();
        d_rd = 1;
        busy_cycles = 0; addr_bad = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mem_rd) begin
                busy_cycles++;
                if (mem_addr !== 16'h0040) addr_bad++;
                d_addr = 16'h7777;
            end
            if (d_done) begin
                seen = 1;
                check("timeout err", err, 1);
                check("timeout rdata", d_rdata, 16'h0000);
                check("timeout cmd dropped", mem_rd, 0);
            end
            next_cycle();
        end
        check("timeout done seen", seen, 1);
        check("timeout busy cycles", busy_cycles, 15);
        check("timeout addr stable", addr_bad, 0);

        // Reset while BUSY_I abandons the access without a response.
        do_reset();
        i_req = 1;
        next_cycle();
        @(negedge clk);
        check("rst busy mem_rd", mem_rd, 1);
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0; i_req = 0;
        @(negedge clk);
        check("rst after mem_rd", mem_rd, 0);
        check("rst after err", err, 0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (i_done) seen = 1;
            next_cycle();
        end
        check("rst no i_done", seen, 0);

        // Request withdrawn mid-access still gets its response.
        do_reset();
        d_rd = 1;
        next_cycle();
        d_rd = 0;
        @(negedge clk);
        check("withdraw mem_rd", mem_rd, 1);
        next_cycle();
        mem_done = 1; mem_rdata = 16'hC0DE;
        next_cycle();
        mem_done = 0;
        @(negedge clk);
        check("withdraw d_done", d_done, 1);
        check("withdraw d_rdata", d_rdata, 16'hC0DE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
